conv_layer_input_ctrl: RTL and testbench
========================================

// Module: conv_layer_input_ctrl
// PURPOSE
// - Sequencer for the conv-layer 3-row input line buffer: drives buffer_cmd/buffer_array_idx, gates upstream pixel stream.
// - Preloads KERNEL_SIZE rows, then per output row presents rows 0..2 for KERNEL_SIZE shift cycles each, one bias cycle, rotates in next row.
// - Sits between the image pixel source and the input buffer; shift_idx/bias_sel feed the kernel MAC array.
// PARAMETERS
// - INPUT_SIZE      8  pixels per image row (= buffer row width)
// - IMAGE_ROWS      8  rows per frame
// - KERNEL_SIZE     3  kernel rows/cols; fixed at 3 (buffer has 3 arrays)
// - ROW_CNT_WIDTH   4  width of row counters; must hold IMAGE_ROWS
// PORTS
// - clk               in   1  clock, rising edge
// - rst               in   1  asynchronous reset, active-high
// - start             in   1  frame start request; sampled only in IDLE
// - pixel_valid       in   1  upstream pixel available
// - pixel_ready       out  1  controller accepts pixel this cycle (buffer loading)
// - buffer_load_ack   in   1  1-cycle pulse from buffer: row load complete
// - buffer_cmd        out  2  0 IDLE, 1 LOAD, 2 READ
// - buffer_array_idx  out  2  buffer array selected for READ (0..2)
// - shift_idx         out  2  kernel column shift, 0..KERNEL_SIZE-1, valid in READ
// - bias_sel          out  1  MAC operand = FLOAT32_ONE this cycle
// - row_done          out  1  1-cycle pulse at end of each output row
// - frame_done        out  1  1-cycle pulse after last output row
// - busy              out  1  high in every state except IDLE
// - err               out  1  sticky: ack outside LOAD phase; cleared on accepted start
// BEHAVIOUR
// - All outputs registered; reset: state IDLE, buffer_cmd 0, idx 0, shift 0, all 1-bit outputs 0, counters 0.
// - States: IDLE, PRELOAD, ROW0, ROW1, ROW2, BIAS, LOAD, DONE.
// - IDLE: start=1 -> PRELOAD next cycle; preload_cnt, out_row_cnt cleared; err cleared.
// - PRELOAD: buffer_cmd=LOAD, pixel_ready=1; each ack increments preload_cnt; ack with preload_cnt==2 -> ROW0.
// - ROWn (n=0,1,2): buffer_cmd=READ, array_idx=n, shift_idx counts 0,1,2 one per cycle; shift 2 -> ROW(n+1), ROW2 -> BIAS.
// - BIAS: exactly 1 cycle, buffer_cmd=IDLE, bias_sel=1; row_done=1 same cycle; out_row_cnt++.
//   - out_row_cnt (pre-increment) == IMAGE_ROWS-KERNEL_SIZE -> DONE; else -> LOAD.
// - LOAD: buffer_cmd=LOAD, pixel_ready=1 (buffer rotates arrays and fills array 2); ack -> ROW0.
// - DONE: 1 cycle, frame_done=1, buffer_cmd=IDLE -> IDLE. Frame = IMAGE_ROWS-KERNEL_SIZE+1 output rows (6 default).
// - Per output row READ/bias occupancy: 3*KERNEL_SIZE+1 = 10 cycles, no bubbles between ROW states.
// - pixel_ready depends only on state, never on pixel_valid (no comb loop); stalls on pixel_valid=0 are buffer-side.
// - ack in any state other than PRELOAD/LOAD: ignored for sequencing, err<=1.
// - start while busy: ignored, no effect on err.
// - start and ack same cycle in IDLE: start taken, ack flags err.
// - Reset mid-frame: immediate return to reset values; no partial-frame recovery, next start restarts from PRELOAD.
// - Counter widths: preload_cnt 2 bits, shift 2 bits, out_row_cnt ROW_CNT_WIDTH; no wrap possible in legal sequence.
// STRUCTURE
// - Shared conv_layer_param.v: BUFFER_CMD_IDLE/LOAD/READ codes, controller state encodings, INPUT_SIZE,
//   KERNEL_SIZE, FLOAT32_ONE; global_define.v keeps DATA_WIDTH.
// - Single module: one FSM (next-state comb + state reg) plus preload, shift, out-row counters. No sub-module.
// TESTING
// - Reset then start=1 one cycle -> cycle+1 busy=1, buffer_cmd=1, pixel_ready=1; no ack -> stays PRELOAD indefinitely.
// - Buffer model acks after 8 accepted pixels, 3 acks -> next cycle cmd=2 idx=0 shift 0,1,2; idx1; idx2; bias_sel=1 + row_done.
// - Full frame, pixel_valid=1 -> exactly 6 row_done pulses, 5 LOAD phases, then 1 frame_done pulse, busy=0 next cycle.
// - Ack injected during ROW1 -> err=1, sequence unchanged (ROW2 follows); next start clears err.
// - start pulsed during ROW0 and during LOAD -> ignored, row count and frame_done timing unchanged.
// - rst asserted in LOAD of row 3 -> outputs zero same cycle (async); new start -> full 6-row frame completes.

Source files
------------

// File: rtl/conv_layer_input_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// conv_layer_input_ctrl_pkg
// Shared constants and types for the conv-layer input line-buffer sequencer:
// buffer command codes, controller state encoding, image/kernel geometry and
// the FP32 constant the MAC array uses as the bias operand.
// ----------------------------------------------------------------------------
package conv_layer_input_ctrl_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INPUT_SIZE  = 8;
  localparam int KERNEL_SIZE = 3;

  // IEEE-754 single precision 1.0, selected as MAC operand when bias_sel=1
  localparam logic [DATA_WIDTH-1:0] FLOAT32_ONE = 32'h3F80_0000;

  localparam logic [1:0] BUFFER_CMD_IDLE = 2'd0;
  localparam logic [1:0] BUFFER_CMD_LOAD = 2'd1;
  localparam logic [1:0] BUFFER_CMD_READ = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_ROW0    = 3'd2,
    ST_ROW1    = 3'd3,
    ST_ROW2    = 3'd4,
    ST_BIAS    = 3'd5,
    ST_LOAD    = 3'd6,
    ST_DONE    = 3'd7
  } ctrl_state_t;

endpackage

// File: rtl/conv_layer_input_ctrl_if.sv
// ----------------------------------------------------------------------------
// conv_layer_input_ctrl_if
// Bundles the sequencer's control/handshake signals.
//   master : the controller (drives buffer_cmd, idx, shift, status flags)
//   slave  : the environment (pixel source, line buffer, MAC array, host)
// Signals:
//   start, pixel_valid, buffer_load_ack          -> controller
//   pixel_ready, buffer_cmd, buffer_array_idx,
//   shift_idx, bias_sel, row_done, frame_done,
//   busy, err                                    <- controller
// ----------------------------------------------------------------------------
interface conv_layer_input_ctrl_if;

  logic       start;
  logic       pixel_valid;
  logic       pixel_ready;
  logic       buffer_load_ack;
  logic [1:0] buffer_cmd;
  logic [1:0] buffer_array_idx;
  logic [1:0] shift_idx;
  logic       bias_sel;
  logic       row_done;
  logic       frame_done;
  logic       busy;
  logic       err;

  modport master (
    input  start, pixel_valid, buffer_load_ack,
    output pixel_ready, buffer_cmd, buffer_array_idx, shift_idx,
           bias_sel, row_done, frame_done, busy, err
  );

  modport slave (
    output start, pixel_valid, buffer_load_ack,
    input  pixel_ready, buffer_cmd, buffer_array_idx, shift_idx,
           bias_sel, row_done, frame_done, busy, err
  );

endinterface

// File: rtl/conv_layer_input_ctrl.sv
// ----------------------------------------------------------------------------
// conv_layer_input_ctrl
// Sequencer for the 3-row input line buffer of the conv layer. Preloads
// KERNEL_SIZE rows, then for every output row presents buffer arrays 0,1,2
// for KERNEL_SIZE shift cycles each, spends one cycle on the bias operand,
// and loads the next image row into the buffer.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - conv_layer_input_ctrl_if.master (handshake, buffer control,
//          MAC control and status; all outputs registered)
// ----------------------------------------------------------------------------
module conv_layer_input_ctrl
  import conv_layer_input_ctrl_pkg::*;
#(
  parameter int IMAGE_ROWS    = 8,
  parameter int ROW_CNT_WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  conv_layer_input_ctrl_if.master bus
);

  localparam logic [1:0] PRELOAD_LAST = 2'(KERNEL_SIZE - 1);
  localparam logic [1:0] SHIFT_LAST   = 2'(KERNEL_SIZE - 1);
  localparam logic [ROW_CNT_WIDTH-1:0] LAST_OUT_ROW =
    ROW_CNT_WIDTH'(IMAGE_ROWS - KERNEL_SIZE);

  ctrl_state_t              state, next_state;
  logic [1:0]               preload_cnt, preload_next;
  logic [1:0]               shift_cnt, shift_next;
  logic [ROW_CNT_WIDTH-1:0] out_row_cnt, out_row_next;
  logic                     err_next;

  logic [1:0] cmd_d, idx_d;
  logic       ready_d, bias_d, row_done_d, frame_done_d, busy_d;

  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      preload_cnt <= '0;
      shift_cnt   <= '0;
      out_row_cnt <= '0;
    end else begin
      state       <= next_state;
      preload_cnt <= preload_next;
      shift_cnt   <= shift_next;
      out_row_cnt <= out_row_next;
    end
  end

  // next-state and counter update; an ack outside a loading phase never
  // alters sequencing, it only raises the sticky error flag
  always_comb begin
    next_state   = state;
    preload_next = preload_cnt;
    shift_next   = shift_cnt;
    out_row_next = out_row_cnt;
    err_next     = bus.err;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          next_state   = ST_PRELOAD;
          preload_next = '0;
          out_row_next = '0;
          err_next     = 1'b0;
        end
      end
      ST_PRELOAD: begin
        if (bus.buffer_load_ack) begin
          preload_next = preload_cnt + 2'd1;
          if (preload_cnt == PRELOAD_LAST) begin
            next_state = ST_ROW0;
            shift_next = '0;
          end
        end
      end
      ST_ROW0, ST_ROW1, ST_ROW2: begin
        if (shift_cnt == SHIFT_LAST) begin
          shift_next = '0;
          case (state)
            ST_ROW0: next_state = ST_ROW1;
            ST_ROW1: next_state = ST_ROW2;
            default: next_state = ST_BIAS;
          endcase
        end else begin
          shift_next = shift_cnt + 2'd1;
        end
      end
      ST_BIAS: begin
        out_row_next = out_row_cnt + 1'b1;
        next_state   = (out_row_cnt == LAST_OUT_ROW) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.buffer_load_ack) begin
          next_state = ST_ROW0;
          shift_next = '0;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase

    if (bus.buffer_load_ack && (state != ST_PRELOAD) && (state != ST_LOAD)) begin
      err_next = 1'b1;
    end
  end

  // output decode from the upcoming state so the registered outputs line up
  // with the state they describe
  always_comb begin
    cmd_d        = BUFFER_CMD_IDLE;
    idx_d        = 2'd0;
    ready_d      = 1'b0;
    bias_d       = 1'b0;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (next_state != ST_IDLE);
    case (next_state)
      ST_PRELOAD, ST_LOAD: begin
        cmd_d   = BUFFER_CMD_LOAD;
        ready_d = 1'b1;
      end
      ST_ROW0: cmd_d = BUFFER_CMD_READ;
      ST_ROW1: begin
        cmd_d = BUFFER_CMD_READ;
        idx_d = 2'd1;
      end
      ST_ROW2: begin
        cmd_d = BUFFER_CMD_READ;
        idx_d = 2'd2;
      end
      ST_BIAS: begin
        bias_d     = 1'b1;
        row_done_d = 1'b1;
      end
      ST_DONE: frame_done_d = 1'b1;
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.buffer_cmd       <= BUFFER_CMD_IDLE;
      bus.buffer_array_idx <= 2'd0;
      bus.shift_idx        <= 2'd0;
      bus.pixel_ready      <= 1'b0;
      bus.bias_sel         <= 1'b0;
      bus.row_done         <= 1'b0;
      bus.frame_done       <= 1'b0;
      bus.busy             <= 1'b0;
      bus.err              <= 1'b0;
    end else begin
      bus.buffer_cmd       <= cmd_d;
      bus.buffer_array_idx <= idx_d;
      bus.shift_idx        <= shift_next;
      bus.pixel_ready      <= ready_d;
      bus.bias_sel         <= bias_d;
      bus.row_done         <= row_done_d;
      bus.frame_done       <= frame_done_d;
      bus.busy             <= busy_d;
      bus.err              <= err_next;
    end
  end

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_conv_layer_input_ctrl
// Drives the sequencer with a line-buffer model (ack after INPUT_SIZE accepted
// pixels), random pixel_valid and random start requests while busy, and
// compares every cycle against a frame-level model that tracks progress as a
// 10-cycle window per output row.
// ----------------------------------------------------------------------------
module tb_conv_layer_input_ctrl;
  import conv_layer_input_ctrl_pkg::*;

  localparam int ROWS_PER_FRAME = 8 - KERNEL_SIZE + 1;
  localparam int ROW_WINDOW     = 3 * KERNEL_SIZE + 1;
  localparam int FRAME_BUDGET   = 3000;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_READ = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic rst;
  conv_layer_input_ctrl_if bus();

  conv_layer_input_ctrl #(.IMAGE_ROWS(8), .ROW_CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // frame-level reference model
  int m_mode, m_acks, m_k, m_row;
  bit m_err;

  // buffer model and stimulus knobs
  int valid_mode = 0;
  bit spam_en    = 1'b0;
  int pix_cnt    = 0;
  bit ack_pending = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model advances on the same edge as the DUT, from the inputs the bench set
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_acks = 0; m_k = 0; m_row = 0; m_err = 1'b0;
    end else begin
      if (m_mode == M_IDLE && bus.start) m_err = 1'b0;
      if (bus.buffer_load_ack && m_mode != M_WAIT) m_err = 1'b1;
      case (m_mode)
        M_IDLE: if (bus.start) begin
          m_mode = M_WAIT; m_acks = KERNEL_SIZE; m_row = 0;
        end
        M_WAIT: if (bus.buffer_load_ack) begin
          m_acks--;
          if (m_acks == 0) begin m_mode = M_READ; m_k = 0; end
        end
        M_READ: begin
          if (m_k == ROW_WINDOW - 1) begin
            m_row++;
            if (m_row == ROWS_PER_FRAME) m_mode = M_DONE;
            else begin m_mode = M_WAIT; m_acks = 1; end
          end else m_k++;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic checkOutput();
    int e_cmd;
    bit in_read;
    in_read = (m_mode == M_READ) && (m_k < ROW_WINDOW - 1);
    e_cmd = (m_mode == M_WAIT) ? 1 : (in_read ? 2 : 0);
    check("busy", bus.busy, int'(m_mode != M_IDLE));
    check("buffer_cmd", bus.buffer_cmd, e_cmd);
    check("pixel_ready", bus.pixel_ready, int'(m_mode == M_WAIT));
    check("bias_sel", bus.bias_sel, int'(m_mode == M_READ && m_k == ROW_WINDOW - 1));
    check("row_done", bus.row_done, int'(m_mode == M_READ && m_k == ROW_WINDOW - 1));
    check("frame_done", bus.frame_done, int'(m_mode == M_DONE));
    check("err", bus.err, int'(m_err));
    if (in_read) begin
      check("array_idx", bus.buffer_array_idx, m_k / KERNEL_SIZE);
      check("shift_idx", bus.shift_idx, m_k % KERNEL_SIZE);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) checkOutput();

  // sets inputs for the coming edge, then advances to the next negedge
  task automatic applyStimulus(input bit do_start, input bit extra_ack);
    bit ack_now, v;
    ack_now = ack_pending;
    ack_pending = 1'b0;
    case (valid_mode)
      2: v = 1'b1;
      1: v = ($urandom_range(0, 3) != 0);
      default: v = 1'b0;
    endcase
    if (!ack_now && bus.pixel_ready && v) begin
      pix_cnt++;
      if (pix_cnt == INPUT_SIZE) begin pix_cnt = 0; ack_pending = 1'b1; end
    end
    bus.pixel_valid     = v;
    bus.buffer_load_ack = ack_now | extra_ack;
    bus.start = do_start | (spam_en && m_mode != M_IDLE && $urandom_range(0, 7) == 0);
    @(negedge clk);
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_cmd", bus.buffer_cmd, 0);
    check("rst_ready", bus.pixel_ready, 0);
    check("rst_err", bus.err, 0);
    bus.start = 1'b0; bus.buffer_load_ack = 1'b0; bus.pixel_valid = 1'b0;
    pix_cnt = 0; ack_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runFrame(input bit start_ack, input int stall, input bit win_chk,
                          input bit inj_row1, input int rst_row, input bit spam,
                          output int rows, output int loads, output int frames);
    bit prev_rd, injected, done_seen, inj;
    int cyc, win_i, saved_mode;
    rows = 0; loads = 0; frames = 0; prev_rd = 0; injected = 0;
    done_seen = 0; cyc = 0; win_i = 0;
    spam_en = spam;
    applyStimulus(1'b1, start_ack);
    check("start_busy", bus.busy, 1);
    check("start_cmd", bus.buffer_cmd, 1);
    check("start_ready", bus.pixel_ready, 1);
    check("start_err", bus.err, int'(start_ack));
    saved_mode = valid_mode;
    valid_mode = 0;
    for (int i = 0; i < stall; i++) begin
      applyStimulus(1'b0, 1'b0);
      check("preload_hold", bus.buffer_cmd, 1);
    end
    valid_mode = saved_mode;
    while (!done_seen && cyc < FRAME_BUDGET) begin
      if (win_chk && win_i < ROW_WINDOW && (win_i > 0 || bus.buffer_cmd == 2)) begin
        if (win_i < ROW_WINDOW - 1) begin
          check("win_cmd", bus.buffer_cmd, 2);
          check("win_idx", bus.buffer_array_idx, win_i / 3);
          check("win_shift", bus.shift_idx, win_i % 3);
        end else begin
          check("win_bias", bus.bias_sel, 1);
          check("win_row_done", bus.row_done, 1);
        end
        win_i++;
      end
      if (bus.row_done) rows++;
      if (prev_rd && bus.buffer_cmd == 1) loads++;
      prev_rd = bus.row_done;
      if (bus.frame_done) begin
        frames++;
        done_seen = 1'b1;
      end else if (rst_row > 0 && rows == rst_row && bus.buffer_cmd == 1) begin
        doReset();
        return;
      end else begin
        inj = 1'b0;
        if (inj_row1 && !injected && bus.buffer_cmd == 2 && bus.buffer_array_idx == 1) begin
          inj = 1'b1;
          injected = 1'b1;
        end
        applyStimulus(1'b0, inj);
        if (inj) begin
          check("err_after_stray_ack", bus.err, 1);
          check("stray_ack_idx", bus.buffer_array_idx, 1);
        end
        cyc++;
      end
    end
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL frame_timeout: got no frame_done expected one within %0d cycles", FRAME_BUDGET);
    end else begin
      spam_en = 1'b0;
      applyStimulus(1'b0, 1'b0);
      check("busy_after_done", bus.busy, 0);
    end
  endtask

  initial begin
    int rows, loads, frames;
    rst = 1'b1;
    bus.start = 1'b0; bus.pixel_valid = 1'b0; bus.buffer_load_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    check("reset_busy", bus.busy, 0);
    check("reset_cmd", bus.buffer_cmd, 0);
    check("reset_idx", bus.buffer_array_idx, 0);
    check("reset_shift", bus.shift_idx, 0);
    check("reset_frame_done", bus.frame_done, 0);

    $display("[TB] frame 1: preload stall, row window");
    valid_mode = 1;
    runFrame(1'b0, 20, 1'b1, 1'b0, 0, 1'b0, rows, loads, frames);
    check("f1_rows", rows, 6);
    check("f1_loads", loads, 5);
    check("f1_frames", frames, 1);

    $display("[TB] frame 2: stray ack in ROW1, start spam, pixel_valid=1");
    valid_mode = 2;
    runFrame(1'b0, 0, 1'b0, 1'b1, 0, 1'b1, rows, loads, frames);
    check("f2_rows", rows, 6);
    check("f2_loads", loads, 5);
    check("f2_frames", frames, 1);

    $display("[TB] frame 3: start clears err, reset in LOAD of row 3");
    valid_mode = 1;
    runFrame(1'b0, 0, 1'b0, 1'b0, 3, 1'b1, rows, loads, frames);
    check("f3_rows_before_reset", rows, 3);

    $display("[TB] frame 4: start with ack in IDLE, full frame after reset");
    runFrame(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, rows, loads, frames);
    check("f4_rows", rows, 6);
    check("f4_loads", loads, 5);
    check("f4_frames", frames, 1);

    repeat (3) applyStimulus(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
